vector_register_file: RTL and testbench



---
 rtl/vector_pkg.sv | 13 +
 rtl/vreg_read_sequencer.sv | 65 ++++++
 rtl/vector_register_file.sv | 65 ++++++
 tb/tb_vector_register_file.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// vector_pkg: shared defaults, index/length typedefs and read-port state enum for the vector register file
package vector_pkg;
  localparam int VECTOR_REG_WIDTH = 64;
  localparam int VECTOR_REG_DEPTH = 64;
  localparam int NUM_VREGS        = 8;
  localparam int VREG_IDX_W       = $clog2(NUM_VREGS);
  localparam int ELEM_IDX_W       = $clog2(VECTOR_REG_DEPTH);
  localparam int VLEN_W           = ELEM_IDX_W + 1;
  typedef logic [VREG_IDX_W-1:0] vreg_idx_t;
  typedef logic [ELEM_IDX_W-1:0] elem_idx_t;
  typedef logic [VLEN_W-1:0]     vlen_t;
  typedef enum logic {IDLE, STREAM} rd_state_e;
endpackage

// File: rtl/vreg_read_sequencer.sv
// vreg_read_sequencer: per-port IDLE/STREAM sequencer producing the array index to load each cycle
// Ports: clk, reset_n (async active-low); i_req_valid/o_req_ready/i_req_vreg/i_req_vlen request handshake;
//        o_ld/o_vreg/o_elem select the element loaded into the port's data register this edge;
//        o_valid/o_last registered stream qualifiers.
module vreg_read_sequencer import vector_pkg::*; #(
  parameter int DEPTH  = VECTOR_REG_DEPTH,
  parameter int NVREGS = NUM_VREGS,
  parameter int VI     = $clog2(NVREGS),
  parameter int EI     = $clog2(DEPTH),
  parameter int VL     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [VI-1:0] i_req_vreg,
  input  logic [VL-1:0] i_req_vlen,
  output logic          o_ld,
  output logic [VI-1:0] o_vreg,
  output logic [EI-1:0] o_elem,
  output logic          o_valid,
  output logic          o_last
);
  localparam logic [VL-1:0] DEPTH_V = VL'(DEPTH);
  rd_state_e     r_state;
  logic [VI-1:0] r_vreg;
  logic [EI-1:0] r_cnt;
  logic [VL-1:0] r_vlen;
  logic          r_valid;
  logic          r_last;
  logic          w_accept;
  logic [VL-1:0] w_eff;
  assign o_req_ready = (r_state == IDLE) || (r_valid && r_last);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_eff       = (i_req_vlen > DEPTH_V) ? DEPTH_V : i_req_vlen;
  // acceptance only happens in STREAM once the last element is out, so the two load sources never overlap
  assign o_ld        = (w_accept && w_eff != '0) || (r_state == STREAM && !r_last);
  assign o_vreg      = w_accept ? i_req_vreg : r_vreg;
  assign o_elem      = w_accept ? '0 : r_cnt;
  assign o_valid     = r_valid;
  assign o_last      = r_last;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_vreg  <= '0;
      r_cnt   <= '0;
      r_vlen  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_state <= (w_eff == '0) ? IDLE : STREAM;
      r_vreg  <= i_req_vreg;
      r_cnt   <= EI'(1);
      r_vlen  <= w_eff;
      r_valid <= w_eff != '0;
      r_last  <= w_eff == VL'(1);
    end else if (r_state == STREAM) begin
      r_state <= r_last ? IDLE : STREAM;
      r_valid <= !r_last;
      // counter may wrap after loading DEPTH-1, but r_last stops any further load
      r_cnt   <= r_cnt + 1'b1;
      r_last  <= !r_last && (VL'(r_cnt) == r_vlen - VL'(1));
    end
  end
endmodule

// File: rtl/vector_register_file.sv
// vector_register_file: NUM_VREGS x DEPTH vector storage, one element write port, NUM_READ_PORTS streaming read ports
// Ports: clk, reset_n (async active-low); rd_req_* request per port; rd_data_valid/rd_data/rd_data_last registered
//        stream outputs per port; wr_en/wr_vreg/wr_elem/wr_data element write.
// Option: define VREG_BYPASS_EN to forward same-edge write data into a port reading that element.
module vector_register_file import vector_pkg::*; #(
  parameter int VECTOR_REG_WIDTH = vector_pkg::VECTOR_REG_WIDTH,
  parameter int VECTOR_REG_DEPTH = vector_pkg::VECTOR_REG_DEPTH,
  parameter int NUM_VREGS        = vector_pkg::NUM_VREGS,
  parameter int NUM_READ_PORTS   = 2
) (
  input  logic                                                 clk,
  input  logic                                                 reset_n,
  input  logic [NUM_READ_PORTS-1:0]                            rd_req_valid,
  output logic [NUM_READ_PORTS-1:0]                            rd_req_ready,
  input  logic [NUM_READ_PORTS-1:0][$clog2(NUM_VREGS)-1:0]     rd_req_vreg,
  input  logic [NUM_READ_PORTS-1:0][$clog2(VECTOR_REG_DEPTH):0] rd_req_vlen,
  output logic [NUM_READ_PORTS-1:0]                            rd_data_valid,
  output logic [NUM_READ_PORTS-1:0][VECTOR_REG_WIDTH-1:0]      rd_data,
  output logic [NUM_READ_PORTS-1:0]                            rd_data_last,
  input  logic                                                 wr_en,
  input  logic [$clog2(NUM_VREGS)-1:0]                         wr_vreg,
  input  logic [$clog2(VECTOR_REG_DEPTH)-1:0]                  wr_elem,
  input  logic [VECTOR_REG_WIDTH-1:0]                          wr_data
);
  localparam int VI = $clog2(NUM_VREGS);
  localparam int EI = $clog2(VECTOR_REG_DEPTH);
  logic [NUM_VREGS-1:0][VECTOR_REG_DEPTH-1:0][VECTOR_REG_WIDTH-1:0] r_mem;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_mem <= '0;
    else if (wr_en) r_mem[wr_vreg][wr_elem] <= wr_data;
  end
  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    logic                        w_ld;
    logic [VI-1:0]               w_vreg;
    logic [EI-1:0]               w_elem;
    logic                        w_fwd;
    logic [VECTOR_REG_WIDTH-1:0] r_data;
    vreg_read_sequencer #(
      .DEPTH  (VECTOR_REG_DEPTH),
      .NVREGS (NUM_VREGS)
    ) u_seq (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_req_valid (rd_req_valid[p]),
      .o_req_ready (rd_req_ready[p]),
      .i_req_vreg  (rd_req_vreg[p]),
      .i_req_vlen  (rd_req_vlen[p]),
      .o_ld        (w_ld),
      .o_vreg      (w_vreg),
      .o_elem      (w_elem),
      .o_valid     (rd_data_valid[p]),
      .o_last      (rd_data_last[p])
    );
`ifdef VREG_BYPASS_EN
    assign w_fwd = wr_en && wr_vreg == w_vreg && wr_elem == w_elem;
`else
    assign w_fwd = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_data <= '0;
      else if (w_ld) r_data <= w_fwd ? wr_data : r_mem[w_vreg][w_elem];
    end
    assign rd_data[p] = r_data;
  end
endmodule

// File: tb/tb_vector_register_file.sv
// tb_vector_register_file: table-driven directed bench for vector_register_file
module tb_vector_register_file;
  logic             clk;
  logic             reset_n;
  logic [1:0]       rd_req_valid;
  logic [1:0]       rd_req_ready;
  logic [1:0][2:0]  rd_req_vreg;
  logic [1:0][6:0]  rd_req_vlen;
  logic [1:0]       rd_data_valid;
  logic [1:0][63:0] rd_data;
  logic [1:0]       rd_data_last;
  logic             wr_en;
  logic [2:0]       wr_vreg;
  logic [5:0]       wr_elem;
  logic [63:0]      wr_data;
  logic [63:0]      model [8][64];
  int               errors = 0;
  int               checks = 0;
  typedef struct {
    int          port;
    int          vreg;
    int          vlen;
    int          exp_n;
    logic [63:0] exp_first;
    logic [63:0] exp_lastd;
  } vec_t;
  vec_t vt [8];

  vector_register_file dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_vreg   (rd_req_vreg),
    .rd_req_vlen   (rd_req_vlen),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .rd_data_last  (rd_data_last),
    .wr_en         (wr_en),
    .wr_vreg       (wr_vreg),
    .wr_elem       (wr_elem),
    .wr_data       (wr_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input int v, input int e, input logic [63:0] d);
    wr_en = 1; wr_vreg = 3'(v); wr_elem = 6'(e); wr_data = d;
    tick;
    wr_en = 0;
    model[v][e] = d;
  endtask

  task automatic run_stream(input int p, input int v, input int vl, input int n,
                            input logic [63:0] ef, input logic [63:0] el, input string nm);
    rd_req_valid[p] = 1; rd_req_vreg[p] = 3'(v); rd_req_vlen[p] = 7'(vl);
    tick;
    rd_req_valid[p] = 0;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s valid k%0d", nm, k), 64'(rd_data_valid[p]), 64'd1);
      chk($sformatf("%s data k%0d", nm, k), rd_data[p], model[v][k]);
      chk($sformatf("%s last k%0d", nm, k), 64'(rd_data_last[p]), 64'(k == n - 1));
      if (k == 0) chk($sformatf("%s first", nm), rd_data[p], ef);
      if (k == n - 1) chk($sformatf("%s lastdata", nm), rd_data[p], el);
      tick;
    end
    chk($sformatf("%s idle valid", nm), 64'(rd_data_valid[p]), 64'd0);
    chk($sformatf("%s idle ready", nm), 64'(rd_req_ready[p]), 64'd1);
  endtask

  initial begin
    reset_n = 0; rd_req_valid = '0; rd_req_vreg = '0; rd_req_vlen = '0;
    wr_en = 0; wr_vreg = '0; wr_elem = '0; wr_data = '0;
    for (int v = 0; v < 8; v++) for (int e = 0; e < 64; e++) model[v][e] = '0;
    #3;
    chk("reset ready", 64'(rd_req_ready), 64'h3);
    chk("reset valid", 64'(rd_data_valid), 64'h0);
    chk("reset last", 64'(rd_data_last), 64'h0);
    chk("reset data0", rd_data[0], 64'h0);
    chk("reset data1", rd_data[1], 64'h0);
    tick; tick;
    reset_n = 1;
    tick;
    chk("post-reset ready", 64'(rd_req_ready), 64'h3);

    run_stream(0, 3, 4, 4, 64'h0, 64'h0, "v3 zeros");

    for (int e = 0; e < 64; e++) wr(2, e, 64'h100 + 64'(e));
    for (int e = 0; e < 64; e++) wr(1, e, 64'hA000 + 64'(e));

    vt[0] = '{0, 3, 4,   4,  64'h0,     64'h0};
    vt[1] = '{1, 2, 64,  64, 64'h100,   64'h13F};
    vt[2] = '{0, 2, 100, 64, 64'h100,   64'h13F};
    vt[3] = '{1, 1, 5,   5,  64'hA000,  64'hA004};
    vt[4] = '{0, 1, 0,   0,  64'h0,     64'h0};
    vt[5] = '{1, 2, 1,   1,  64'h100,   64'h100};
    vt[6] = '{0, 7, 64,  64, 64'h0,     64'h0};
    vt[7] = '{1, 1, 65,  64, 64'hA000,  64'hA03F};
    for (int i = 0; i < 8; i++)
      run_stream(vt[i].port, vt[i].vreg, vt[i].vlen, vt[i].exp_n,
                 vt[i].exp_first, vt[i].exp_lastd, $sformatf("vec%0d", i));

    // back-to-back: second request accepted on the last-element edge of the first
    begin
      int vcnt;
      vcnt = 0;
      rd_req_valid[0] = 1; rd_req_vreg[0] = 3'd1; rd_req_vlen[0] = 7'd2;
      tick;
      rd_req_vreg[0] = 3'd2; rd_req_vlen[0] = 7'd3;
      chk("b2b a0 data", rd_data[0], 64'hA000);
      chk("b2b a0 ready", 64'(rd_req_ready[0]), 64'd0);
      vcnt += int'(rd_data_valid[0]);
      tick;
      chk("b2b a1 data", rd_data[0], 64'hA001);
      chk("b2b a1 last", 64'(rd_data_last[0]), 64'd1);
      chk("b2b a1 ready", 64'(rd_req_ready[0]), 64'd1);
      vcnt += int'(rd_data_valid[0]);
      tick;
      rd_req_valid[0] = 0;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("b2b b%0d data", k), rd_data[0], 64'h100 + 64'(k));
        chk($sformatf("b2b b%0d last", k), 64'(rd_data_last[0]), 64'(k == 2));
        vcnt += int'(rd_data_valid[0]);
        tick;
      end
      chk("b2b valid cycles", 64'(vcnt), 64'd5);
      chk("b2b end valid", 64'(rd_data_valid[0]), 64'd0);
    end

    // same-edge write and read of one element
    wr(5, 0, 64'hA);
    wr_en = 1; wr_vreg = 3'd5; wr_elem = 6'd0; wr_data = 64'hB;
    rd_req_valid[0] = 1; rd_req_vreg[0] = 3'd5; rd_req_vlen[0] = 7'd1;
    tick;
    wr_en = 0; rd_req_valid[0] = 0;
`ifdef VREG_BYPASS_EN
    chk("collision data", rd_data[0], 64'hB);
`else
    chk("collision data", rd_data[0], 64'hA);
`endif
    chk("collision last", 64'(rd_data_last[0]), 64'd1);
    model[5][0] = 64'hB;
    tick;
    run_stream(0, 5, 1, 1, 64'hB, 64'hB, "after collision");

    // reset mid-stream
    rd_req_valid[1] = 1; rd_req_vreg[1] = 3'd2; rd_req_vlen[1] = 7'd64;
    tick;
    rd_req_valid[1] = 0;
    for (int k = 0; k < 10; k++) tick;
    chk("mid elem10 data", rd_data[1], 64'h10A);
    chk("mid elem10 valid", 64'(rd_data_valid[1]), 64'd1);
    reset_n = 0;
    #1;
    chk("abort valid", 64'(rd_data_valid), 64'h0);
    chk("abort last", 64'(rd_data_last), 64'h0);
    chk("abort data1", rd_data[1], 64'h0);
    chk("abort ready", 64'(rd_req_ready), 64'h3);
    tick; tick;
    chk("abort held valid", 64'(rd_data_valid), 64'h0);
    reset_n = 1;
    tick;
    chk("after abort valid", 64'(rd_data_valid), 64'h0);
    for (int v = 0; v < 8; v++) for (int e = 0; e < 64; e++) model[v][e] = '0;
    for (int v = 0; v < 8; v++)
      run_stream(v % 2, v, 64, 64, 64'h0, 64'h0, $sformatf("cleared v%0d", v));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
